// File: rtl/cpu_run_ctrl.sv
`timescale 1ns/1ps
// cpu_run_ctrl: run/step/halt sequencer for the 4-bit CPU datapath.
// Issues a one-cycle cpu_en per instruction; stops on breakpoint or self-loop.
module cpu_run_ctrl #(
    parameter int CLK_DIV = 4,
    parameter int ADDR_W  = 4,
    parameter int OP_W    = 4,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run_req,
    input  logic              halt_req,
    input  logic              step_req,
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic [ADDR_W-1:0] pc,
    input  logic [OP_W-1:0]   op,
    input  logic [ADDR_W-1:0] imm,
    output logic              cpu_en,
    output logic [1:0]        state,
    output logic [1:0]        halt_cause,
    output logic              step_done,
    output logic [CNT_W-1:0]  instr_count
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [OP_W-1:0]  OP_JMP_IM = {OP_W{1'b1}};

    typedef enum logic [1:0] {
        S_HALT = 2'b00,
        S_RUN  = 2'b01,
        S_STEP = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        C_NONE = 2'b00,
        C_BP   = 2'b01,
        C_LOOP = 2'b10
    } cause_t;

    state_t           state_q, state_d;
    cause_t           cause_q, cause_d;
    logic [DIV_W-1:0] div_cnt, div_d;
    logic             skip_chk, skip_d;
    logic             en_q, en_d;
    logic             sd_q, sd_d;
    logic             slot;
    logic             bp_hit;
    logic             loop_hit;

    // Resume skips the checks once so a stopped instruction can execute.
    assign slot     = (div_cnt == DIV_LAST);
    assign bp_hit   = bp_en && (pc == bp_addr) && !skip_chk;
    assign loop_hit = (op == OP_JMP_IM) && (imm == pc) && !skip_chk;

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_HALT;
            cause_q  <= C_NONE;
            div_cnt  <= '0;
            skip_chk <= 1'b0;
            en_q     <= 1'b0;
            sd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            div_cnt  <= div_d;
            skip_chk <= skip_d;
            en_q     <= en_d;
            sd_q     <= sd_d;
        end
    end

    // Next state: request priority in HALT, slot decisions in RUN.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        div_d   = div_cnt;
        skip_d  = skip_chk;
        en_d    = 1'b0;
        sd_d    = 1'b0;
        unique case (state_q)
            S_HALT: begin
                if (halt_req) begin
                    state_d = S_HALT;
                end else if (step_req) begin
                    state_d = S_STEP;
                    cause_d = C_NONE;
                end else if (run_req) begin
                    state_d = S_RUN;
                    cause_d = C_NONE;
                    div_d   = '0;
                    skip_d  = 1'b1;
                end
            end
            S_STEP: begin
                state_d = S_HALT;
                if (!halt_req) begin
                    en_d = 1'b1;
                    sd_d = 1'b1;
                end
            end
            S_RUN: begin
                if (slot) begin
                    div_d = '0;
                    if (halt_req) begin
                        state_d = S_HALT;
                        cause_d = C_NONE;
                    end else if (bp_hit) begin
                        state_d = S_HALT;
                        cause_d = C_BP;
                    end else if (loop_hit) begin
                        state_d = S_HALT;
                        cause_d = C_LOOP;
                    end else begin
                        en_d   = 1'b1;
                        skip_d = 1'b0;
                    end
                end else begin
                    div_d = div_cnt + 1'b1;
                    if (halt_req) begin
                        state_d = S_HALT;
                        cause_d = C_NONE;
                    end
                end
            end
            default: begin
                state_d = S_HALT;
                cause_d = C_NONE;
            end
        endcase
    end

    // Retired-instruction counter, one per cycle with cpu_en high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count <= '0;
        end else if (en_q) begin
            instr_count <= instr_count + 1'b1;
        end
    end

`ifndef SYNTHESIS
    // Slots shorter than 2 cycles give the datapath no time to settle.
    always_ff @(posedge clk) begin
        assert (CLK_DIV >= 2)
        else $error("cpu_run_ctrl: CLK_DIV must be >= 2");
    end
`endif

    assign cpu_en     = en_q;
    assign step_done  = sd_q;
    assign state      = state_q;
    assign halt_cause = cause_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
`timescale 1ns/1ps
// tb_cpu_run_ctrl: directed checks of the run/step/halt sequencer.
// Bench plays the datapath: pc advances after each cpu_en when pc_auto is set.
module tb_cpu_run_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run_req = 1'b0;
    logic       halt_req = 1'b0;
    logic       step_req = 1'b0;
    logic       bp_en = 1'b0;
    logic [3:0] bp_addr = 4'd0;
    logic [3:0] pc = 4'd0;
    logic [3:0] op = 4'd0;
    logic [3:0] imm = 4'd0;
    logic       cpu_en;
    logic [1:0] state;
    logic [1:0] halt_cause;
    logic       step_done;
    logic [7:0] instr_count;

    logic       pc_auto = 1'b0;
    int         ncmp = 0;
    int         nfail = 0;

    cpu_run_ctrl #(
        .CLK_DIV(4), .ADDR_W(4), .OP_W(4), .CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
        .bp_en(bp_en), .bp_addr(bp_addr),
        .pc(pc), .op(op), .imm(imm),
        .cpu_en(cpu_en), .state(state), .halt_cause(halt_cause),
        .step_done(step_done), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Advance one clock; sample 1 ns after the edge; datapath pc model.
    task automatic tick();
        logic was_en;
        was_en = cpu_en;
        @(posedge clk);
        #1;
        if (pc_auto && was_en) pc = pc + 4'd1;
    endtask

    // Run n cycles; bit k of em/sm holds cpu_en/step_done after edge k.
    task automatic run_for(input int n, output logic [31:0] em,
                           output logic [31:0] sm);
        em = '0;
        sm = '0;
        for (int k = 1; k <= n; k++) begin
            tick();
            em[k] = cpu_en;
            sm[k] = step_done;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // The edge that samples run_req is edge 0; cycle n follows edge n-1.
    task automatic run_pulse();
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        ncmp++;
        if (state !== 2'b00) begin
            $display("FAIL reset_state: got %b want 00", state);
            nfail++;
        end
        ncmp++;
        if (cpu_en !== 1'b0 || step_done !== 1'b0) begin
            $display("FAIL reset_en: got en=%b sd=%b want 0/0",
                     cpu_en, step_done);
            nfail++;
        end
        ncmp++;
        if (halt_cause !== 2'b00 || instr_count !== 8'd0) begin
            $display("FAIL reset_cause_cnt: got %b/%0d want 00/0",
                     halt_cause, instr_count);
            nfail++;
        end
    endtask

    task automatic test_run();
        logic [31:0] em, sm;
        pc = 4'd0;
        op = 4'd0;
        imm = 4'd0;
        pc_auto = 1'b1;
        run_pulse();
        run_for(13, em, sm);
        ncmp++;
        if (em !== 32'h0000_1110) begin
            $display("FAIL run_issue_slots: got %h want 00001110", em);
            nfail++;
        end
        ncmp++;
        if (instr_count !== 8'd3 || state !== 2'b01) begin
            $display("FAIL run_count_state: got %0d/%b want 3/01",
                     instr_count, state);
            nfail++;
        end
        ncmp++;
        if (pc !== 4'd3) begin
            $display("FAIL run_pc: got %0d want 3", pc);
            nfail++;
        end
    endtask

    task automatic test_breakpoint();
        logic [31:0] em, sm;
        bp_en = 1'b1;
        bp_addr = 4'd3;
        run_for(5, em, sm);
        ncmp++;
        if (em !== 32'd0 || state !== 2'b00 || halt_cause !== 2'b01) begin
            $display("FAIL bp_stop: got en=%h st=%b c=%b want 0/00/01",
                     em, state, halt_cause);
            nfail++;
        end
        run_pulse();
        ncmp++;
        if (state !== 2'b01 || halt_cause !== 2'b00) begin
            $display("FAIL bp_resume: got st=%b c=%b want 01/00",
                     state, halt_cause);
            nfail++;
        end
        run_for(8, em, sm);
        ncmp++;
        if (em !== 32'h0000_0110 || pc !== 4'd4) begin
            $display("FAIL bp_past: got en=%h pc=%0d want 00000110/4",
                     em, pc);
            nfail++;
        end
        bp_en = 1'b0;
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        ncmp++;
        if (state !== 2'b00 || instr_count !== 8'd5) begin
            $display("FAIL bp_halt: got st=%b cnt=%0d want 00/5",
                     state, instr_count);
            nfail++;
        end
    endtask

    task automatic test_self_loop();
        logic [31:0] em, sm;
        pc = 4'd6;
        op = 4'b1111;
        imm = 4'd7;
        pc_auto = 1'b1;
        run_pulse();
        run_for(8, em, sm);
        ncmp++;
        if (em !== 32'h10 || state !== 2'b00 || halt_cause !== 2'b10) begin
            $display("FAIL loop_stop: got en=%h st=%b c=%b want 10/00/10",
                     em, state, halt_cause);
            nfail++;
        end
        pc_auto = 1'b0;
        run_pulse();
        ncmp++;
        if (halt_cause !== 2'b00) begin
            $display("FAIL loop_clear: got %b want 00", halt_cause);
            nfail++;
        end
        run_for(4, em, sm);
        ncmp++;
        if (em !== 32'h10) begin
            $display("FAIL loop_resume: got %h want 00000010", em);
            nfail++;
        end
        imm = 4'd6;
        run_for(4, em, sm);
        ncmp++;
        if (em !== 32'h10 || state !== 2'b01) begin
            $display("FAIL loop_imm6: got en=%h st=%b want 10/01",
                     em, state);
            nfail++;
        end
        imm = 4'd7;
        run_for(4, em, sm);
        ncmp++;
        if (em !== 32'd0 || state !== 2'b00 || halt_cause !== 2'b10) begin
            $display("FAIL loop_again: got en=%h st=%b c=%b want 0/00/10",
                     em, state, halt_cause);
            nfail++;
        end
        op = 4'd0;
        imm = 4'd0;
    endtask

    task automatic test_step();
        logic [31:0] em, sm;
        apply_reset();
        pc_auto = 1'b0;
        pc = 4'd9;
        bp_en = 1'b1;
        bp_addr = 4'd9;
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        ncmp++;
        if (state !== 2'b10 || cpu_en !== 1'b0) begin
            $display("FAIL step_enter: got st=%b en=%b want 10/0",
                     state, cpu_en);
            nfail++;
        end
        tick();
        ncmp++;
        if (cpu_en !== 1'b1 || step_done !== 1'b1 || state !== 2'b00) begin
            $display("FAIL step_issue: got en=%b sd=%b st=%b want 1/1/00",
                     cpu_en, step_done, state);
            nfail++;
        end
        tick();
        ncmp++;
        if (cpu_en !== 1'b0 || step_done !== 1'b0 ||
            instr_count !== 8'd1) begin
            $display("FAIL step_after: got en=%b sd=%b cnt=%0d want 0/0/1",
                     cpu_en, step_done, instr_count);
            nfail++;
        end
        step_req = 1'b1;
        run_for(6, em, sm);
        step_req = 1'b0;
        ncmp++;
        if (em !== 32'h54 || sm !== 32'h54) begin
            $display("FAIL step_hold: got en=%h sd=%h want 54/54", em, sm);
            nfail++;
        end
        tick();
        ncmp++;
        if (instr_count !== 8'd4 || state !== 2'b00) begin
            $display("FAIL step_count: got %0d/%b want 4/00",
                     instr_count, state);
            nfail++;
        end
        bp_en = 1'b0;
    endtask

    task automatic test_halt_priority();
        logic [31:0] em, sm;
        halt_req = 1'b1;
        step_req = 1'b1;
        run_req = 1'b1;
        run_for(3, em, sm);
        halt_req = 1'b0;
        step_req = 1'b0;
        run_req = 1'b0;
        ncmp++;
        if (em !== 32'd0 || state !== 2'b00) begin
            $display("FAIL prio_halt: got en=%h st=%b want 0/00", em, state);
            nfail++;
        end
        pc = 4'd0;
        pc_auto = 1'b1;
        run_pulse();
        run_for(4, em, sm);
        ncmp++;
        if (em !== 32'h10) begin
            $display("FAIL prio_run: got %h want 00000010", em);
            nfail++;
        end
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        ncmp++;
        if (state !== 2'b00 || cpu_en !== 1'b0) begin
            $display("FAIL midrun_halt: got st=%b en=%b want 00/0",
                     state, cpu_en);
            nfail++;
        end
        run_for(8, em, sm);
        ncmp++;
        if (em !== 32'd0 || state !== 2'b00) begin
            $display("FAIL midrun_quiet: got en=%h st=%b want 0/00",
                     em, state);
            nfail++;
        end
        pc_auto = 1'b0;
    endtask

    task automatic test_wrap_and_reset();
        apply_reset();
        step_req = 1'b1;
        repeat (510) tick();
        step_req = 1'b0;
        tick();
        ncmp++;
        if (instr_count !== 8'd255 || state !== 2'b00) begin
            $display("FAIL wrap_pre: got %0d/%b want 255/00",
                     instr_count, state);
            nfail++;
        end
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        tick();
        ncmp++;
        if (cpu_en !== 1'b1 || instr_count !== 8'd255) begin
            $display("FAIL wrap_issue: got en=%b cnt=%0d want 1/255",
                     cpu_en, instr_count);
            nfail++;
        end
        tick();
        ncmp++;
        if (instr_count !== 8'd0 || cpu_en !== 1'b0) begin
            $display("FAIL wrap_zero: got cnt=%0d en=%b want 0/0",
                     instr_count, cpu_en);
            nfail++;
        end
        step_req = 1'b1;
        repeat (510) tick();
        step_req = 1'b0;
        tick();
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        tick();
        ncmp++;
        if (cpu_en !== 1'b1 || instr_count !== 8'd255) begin
            $display("FAIL arst_pre: got en=%b cnt=%0d want 1/255",
                     cpu_en, instr_count);
            nfail++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        ncmp++;
        if (cpu_en !== 1'b0 || instr_count !== 8'd0 ||
            state !== 2'b00 || step_done !== 1'b0) begin
            $display("FAIL arst_now: got en=%b cnt=%0d st=%b sd=%b want 0/0/00/0",
                     cpu_en, instr_count, state, step_done);
            nfail++;
        end
        tick();
        rst_n = 1'b1;
        tick();
        ncmp++;
        if (state !== 2'b00 || instr_count !== 8'd0 || cpu_en !== 1'b0) begin
            $display("FAIL arst_after: got st=%b cnt=%0d en=%b want 00/0/0",
                     state, instr_count, cpu_en);
            nfail++;
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_breakpoint();
        test_self_loop();
        test_step();
        test_halt_priority();
        test_wrap_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
